// File: rtl/regr_pkg.sv
// Shared types and widths for the regression point feeder.
// Included by the ROI gate and the feeder top.
package regr_pkg;

    localparam int X_W     = 11;
    localparam int Y_W     = 10;
    localparam int COUNT_W = 13;
    localparam int DROP_W  = 16;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_TAB     = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/roi_gate.sv
// ROI qualification of mask hits plus the per-row stride decimator.
// hit_out is any in-ROI mask hit; emit_out marks the hits kept by the stride.
module roi_gate
    import regr_pkg::*;
#(
    parameter int STRIDE = 4
) (
    input  logic           clk_in,
    input  logic           rst_n_in,
    input  logic           enable_in,
    input  logic           clear_in,
    input  logic           pixel_valid_in,
    input  logic           mask_in,
    input  logic [X_W-1:0] hcount_in,
    input  logic [Y_W-1:0] vcount_in,
    input  logic [X_W-1:0] roi_x0_in,
    input  logic [X_W-1:0] roi_x1_in,
    input  logic [Y_W-1:0] roi_y0_in,
    input  logic [Y_W-1:0] roi_y1_in,
    output logic           hit_out,
    output logic           emit_out
);

    localparam logic [15:0] LAST = 16'(STRIDE - 1);

    logic [15:0]    stride_cnt;
    logic [15:0]    eff_cnt;
    logic [Y_W-1:0] last_row;
    logic           in_x;
    logic           in_y;

    // An inverted ROI fails one of the two compares, so it accepts nothing
    assign in_x = (hcount_in >= roi_x0_in) && (hcount_in <= roi_x1_in);
    assign in_y = (vcount_in >= roi_y0_in) && (vcount_in <= roi_y1_in);

    assign hit_out  = pixel_valid_in && mask_in && in_x && in_y;
    assign eff_cnt  = (vcount_in != last_row) ? '0 : stride_cnt;
    assign emit_out = hit_out && (eff_cnt == '0);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            stride_cnt <= '0;
            last_row   <= '0;
        end else if (clear_in) begin
            stride_cnt <= '0;
        end else if (enable_in && pixel_valid_in) begin
            last_row <= vcount_in;
            if (hit_out) begin
                stride_cnt <= (eff_cnt == LAST) ? '0 : eff_cnt + 16'd1;
            end else begin
                stride_cnt <= eff_cnt;
            end
        end
    end

endmodule

// File: rtl/regr_point_feeder.sv
// Feeds decimated in-ROI mask hits to the regression stage and sequences
// tabulate / result-wait / frame-done with a per-frame point budget.
module regr_point_feeder
    import regr_pkg::*;
#(
    parameter int H_MAX      = 1023,
    parameter int V_MAX      = 767,
    parameter int STRIDE     = 4,
    parameter int MAX_POINTS = 4096,
    parameter int MIN_POINTS = 8,
    parameter int TIMEOUT    = 4096
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic [X_W-1:0]     hcount_in,
    input  logic [Y_W-1:0]     vcount_in,
    input  logic               mask_in,
    input  logic               pixel_valid_in,
    input  logic               frame_end_in,
    input  logic [X_W-1:0]     roi_x0_in,
    input  logic [X_W-1:0]     roi_x1_in,
    input  logic [Y_W-1:0]     roi_y0_in,
    input  logic [Y_W-1:0]     roi_y1_in,
    input  logic               regr_valid_in,
    output logic [X_W-1:0]     x_out,
    output logic [Y_W-1:0]     y_out,
    output logic               valid_out,
    output logic               tabulate_out,
    output logic               frame_done_out,
    output logic               low_conf_out,
    output logic               timeout_out,
    output logic [COUNT_W-1:0] point_count_out,
    output logic [DROP_W-1:0]  dropped_count_out
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]      TO_V  = TW'(TIMEOUT);
    localparam logic [COUNT_W-1:0] MAXP  = COUNT_W'(MAX_POINTS);
    localparam logic [COUNT_W-1:0] MINP  = COUNT_W'(MIN_POINTS);
    localparam logic [X_W-1:0]     HMAXV = X_W'(H_MAX);
    localparam logic [Y_W-1:0]     VMAXV = Y_W'(V_MAX);

    state_e             state;
    logic [COUNT_W-1:0] count;
    logic [TW-1:0]      wait_cnt;
    logic               to_flag;
    logic               legal;
    logic               hit;
    logic               emit;
    logic               accept;
    logic               drop;

    assign legal = pixel_valid_in && (hcount_in <= HMAXV) && (vcount_in <= VMAXV);

    roi_gate #(
        .STRIDE(STRIDE)
    ) u_gate (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .enable_in      (state == ST_COLLECT),
        .clear_in       (state == ST_DONE),
        .pixel_valid_in (legal),
        .mask_in        (mask_in),
        .hcount_in      (hcount_in),
        .vcount_in      (vcount_in),
        .roi_x0_in      (roi_x0_in),
        .roi_x1_in      (roi_x1_in),
        .roi_y0_in      (roi_y0_in),
        .roi_y1_in      (roi_y1_in),
        .hit_out        (hit),
        .emit_out       (emit)
    );

    assign accept = (state == ST_COLLECT) && emit && (count < MAXP);
    // Outside COLLECT every hit is lost; inside, only stride-kept hits over budget
    assign drop = (state == ST_COLLECT) ? (emit && !(count < MAXP)) : hit;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state             <= ST_COLLECT;
            count             <= '0;
            wait_cnt          <= '0;
            to_flag           <= 1'b0;
            x_out             <= '0;
            y_out             <= '0;
            valid_out         <= 1'b0;
            tabulate_out      <= 1'b0;
            frame_done_out    <= 1'b0;
            low_conf_out      <= 1'b0;
            timeout_out       <= 1'b0;
            point_count_out   <= '0;
            dropped_count_out <= '0;
        end else begin
            valid_out      <= 1'b0;
            tabulate_out   <= 1'b0;
            frame_done_out <= 1'b0;
            if (drop && (dropped_count_out != '1)) begin
                dropped_count_out <= dropped_count_out + 16'd1;
            end
            unique case (state)
                ST_COLLECT: begin
                    if (accept) begin
                        valid_out <= 1'b1;
                        x_out     <= hcount_in;
                        y_out     <= vcount_in;
                    end
                    count <= count + COUNT_W'(accept);
                    // An empty frame skips tabulate: the regressor cannot clear on it
                    if (frame_end_in) begin
                        state <= (count != '0 || accept) ? ST_TAB : ST_DONE;
                    end
                end
                ST_TAB: begin
                    tabulate_out <= 1'b1;
                    wait_cnt     <= '0;
                    to_flag      <= 1'b0;
                    state        <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (regr_valid_in) begin
                        state <= ST_DONE;
                    end else if (wait_cnt == TO_V) begin
                        to_flag <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                ST_DONE: begin
                    frame_done_out  <= 1'b1;
                    point_count_out <= count;
                    low_conf_out    <= (count < MINP);
                    timeout_out     <= to_flag;
                    count           <= '0;
                    to_flag         <= 1'b0;
                    state           <= ST_COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regr_point_feeder.sv
// Directed bench for regr_point_feeder: two instances (stride 1 / stride 4 with
// an 8-point cap), sample scoreboards, and handshake latency checks.
module tb_regr_point_feeder;
    import regr_pkg::*;

    localparam int TO_A = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           sel;
    logic [X_W-1:0] hc;
    logic [Y_W-1:0] vc;
    logic           mask, pv, fe, rv;
    logic [X_W-1:0] rx0, rx1;
    logic [Y_W-1:0] ry0, ry1;

    logic [X_W-1:0]     x_a, x_b;
    logic [Y_W-1:0]     y_a, y_b;
    logic               va, vb, tab_a, tab_b, done_a, done_b;
    logic               lc_a, lc_b, to_a, to_b;
    logic [COUNT_W-1:0] pc_a, pc_b;
    logic [DROP_W-1:0]  dr_a, dr_b;

    int n_cmp = 0;
    int n_err = 0;
    logic [20:0] qa[$];
    logic [20:0] qb[$];

    regr_point_feeder #(
        .STRIDE(1), .MAX_POINTS(4096), .MIN_POINTS(8), .TIMEOUT(TO_A)
    ) dut_a (
        .clk_in(clk), .rst_n_in(rst_n),
        .hcount_in(hc), .vcount_in(vc), .mask_in(mask),
        .pixel_valid_in(pv & ~sel), .frame_end_in(fe & ~sel),
        .roi_x0_in(rx0), .roi_x1_in(rx1), .roi_y0_in(ry0), .roi_y1_in(ry1),
        .regr_valid_in(rv & ~sel),
        .x_out(x_a), .y_out(y_a), .valid_out(va), .tabulate_out(tab_a),
        .frame_done_out(done_a), .low_conf_out(lc_a), .timeout_out(to_a),
        .point_count_out(pc_a), .dropped_count_out(dr_a)
    );

    regr_point_feeder #(
        .STRIDE(4), .MAX_POINTS(8), .MIN_POINTS(8), .TIMEOUT(64)
    ) dut_b (
        .clk_in(clk), .rst_n_in(rst_n),
        .hcount_in(hc), .vcount_in(vc), .mask_in(mask),
        .pixel_valid_in(pv & sel), .frame_end_in(fe & sel),
        .roi_x0_in(rx0), .roi_x1_in(rx1), .roi_y0_in(ry0), .roi_y1_in(ry1),
        .regr_valid_in(rv & sel),
        .x_out(x_b), .y_out(y_b), .valid_out(vb), .tabulate_out(tab_b),
        .frame_done_out(done_b), .low_conf_out(lc_b), .timeout_out(to_b),
        .point_count_out(pc_b), .dropped_count_out(dr_b)
    );

    logic               tab_c, done_c, lc_c, to_c;
    logic [COUNT_W-1:0] pc_c;
    logic [DROP_W-1:0]  dr_c;
    assign tab_c  = sel ? tab_b : tab_a;
    assign done_c = sel ? done_b : done_a;
    assign lc_c   = sel ? lc_b : lc_a;
    assign to_c   = sel ? to_b : to_a;
    assign pc_c   = sel ? pc_b : pc_a;
    assign dr_c   = sel ? dr_b : dr_a;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : mon_a
        logic [20:0] e;
        if (va) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_valid", 32'(va), 0);
            end else begin
                e = qa.pop_front();
                chk("a_sample_xy", 32'({x_a, y_a}), 32'(e));
            end
        end
    end

    always @(negedge clk) begin : mon_b
        logic [20:0] e;
        if (vb) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_valid", 32'(vb), 0);
            end else begin
                e = qb.pop_front();
                chk("b_sample_xy", 32'({x_b, y_b}), 32'(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_hits(input int x0, input int n, input int y,
                              input bit fe_last);
        for (int i = 0; i < n; i++) begin
            hc   = 11'(x0 + i);
            vc   = 10'(y);
            mask = 1'b1;
            pv   = 1'b1;
            fe   = fe_last && (i == n - 1);
            tick();
        end
        pv   = 1'b0;
        mask = 1'b0;
        fe   = 1'b0;
    endtask

    task automatic pulse_fe();
        fe = 1'b1;
        tick();
        fe = 1'b0;
    endtask

    task automatic pulse_rv();
        rv = 1'b1;
        tick();
        rv = 1'b0;
    endtask

    task automatic wait_tab(input string tag, input int exp_n);
        int n;
        bit got;
        n   = 0;
        got = 1'b0;
        while (!got && n < 50) begin
            @(negedge clk);
            n++;
            got = tab_c;
        end
        chk({tag, "_tab_latency"}, n, exp_n);
    endtask

    task automatic wait_done(input string tag, input int exp_n,
                             input bit exp_tab);
        int n;
        bit got, saw;
        n   = 0;
        got = 1'b0;
        saw = 1'b0;
        while (!got && n < 6000) begin
            @(negedge clk);
            n++;
            got = done_c;
            saw = saw | tab_c;
        end
        chk({tag, "_done_latency"}, n, exp_n);
        chk({tag, "_tab_seen"}, 32'(saw), 32'(exp_tab));
    endtask

    task automatic status(input string tag, input int pc, input bit lc,
                          input bit to, input int dr);
        chk({tag, "_point_count"}, 32'(pc_c), pc);
        chk({tag, "_low_conf"}, 32'(lc_c), 32'(lc));
        chk({tag, "_timeout"}, 32'(to_c), 32'(to));
        chk({tag, "_dropped"}, 32'(dr_c), dr);
    endtask

    initial begin
        rst_n = 1'b0;
        sel   = 1'b0;
        hc    = '0;
        vc    = '0;
        mask  = 1'b0;
        pv    = 1'b0;
        fe    = 1'b0;
        rv    = 1'b0;
        rx0   = 11'd100;
        rx1   = 11'd199;
        ry0   = 10'd50;
        ry1   = 10'd59;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_a_flags", 32'({va, tab_a, done_a, lc_a, to_a}), 0);
        chk("reset_a_counts", 32'({pc_a, dr_a}), 0);
        chk("reset_b_all", 32'({vb, tab_b, done_b, lc_b, to_b, pc_b}), 0);
        rst_n = 1'b1;
        tick();

        // 1: ten consecutive hits, result after 300 cycles
        for (int i = 0; i < 10; i++) qa.push_back({11'(100 + i), 10'd50});
        drive_hits(100, 10, 50, 1'b0);
        pulse_fe();
        wait_tab("t1", 2);
        chk("t1_x_hold", 32'(x_a), 109);
        repeat (300) tick();
        pulse_rv();
        wait_done("t1", 2, 1'b0);
        status("t1", 10, 1'b0, 1'b0, 0);

        // 4: inverted ROI accepts nothing; empty frame skips tabulate
        rx0 = 11'd300;
        rx1 = 11'd200;
        drive_hits(100, 5, 50, 1'b0);
        pulse_fe();
        wait_done("t4", 2, 1'b0);
        status("t4", 0, 1'b1, 1'b0, 0);
        rx0 = 11'd100;
        rx1 = 11'd199;

        // 5: no regression result -> timeout, then a normal frame
        for (int i = 0; i < 3; i++) qa.push_back({11'(110 + i), 10'd52});
        drive_hits(110, 3, 52, 1'b0);
        pulse_fe();
        wait_tab("t5", 2);
        wait_done("t5", TO_A + 2, 1'b0);
        status("t5", 3, 1'b1, 1'b1, 0);
        for (int i = 0; i < 12; i++) qa.push_back({11'(150 + i), 10'd55});
        drive_hits(150, 12, 55, 1'b0);
        pulse_fe();
        wait_tab("t5b", 2);
        pulse_rv();
        wait_done("t5b", 2, 1'b0);
        status("t5b", 12, 1'b0, 1'b0, 0);

        // 6: last hit coincident with frame_end is counted
        for (int i = 0; i < 5; i++) qa.push_back({11'(100 + i), 10'd59});
        drive_hits(100, 5, 59, 1'b1);
        wait_tab("t6", 2);
        pulse_rv();
        wait_done("t6", 2, 1'b0);
        status("t6", 5, 1'b1, 1'b0, 0);

        // 6b: asynchronous reset while waiting for the result
        for (int i = 0; i < 3; i++) qa.push_back({11'(120 + i), 10'd51});
        drive_hits(120, 3, 51, 1'b0);
        pulse_fe();
        wait_tab("t6b", 2);
        repeat (3) tick();
        chk("t6b_pc_hold", 32'(pc_a), 5);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6b_async_flags", 32'({va, tab_a, done_a, lc_a, to_a}), 0);
        chk("t6b_async_xy", 32'({x_a, y_a}), 0);
        chk("t6b_async_counts", 32'({pc_a, dr_a}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 2: stride 4, stride counter restarts on the new row
        sel = 1'b1;
        rx0 = 11'd0;
        rx1 = 11'd600;
        ry0 = 10'd0;
        ry1 = 10'd100;
        for (int i = 0; i < 14; i += 4) qb.push_back({11'(120 + i), 10'd50});
        for (int i = 0; i < 16; i += 4) qb.push_back({11'(140 + i), 10'd51});
        drive_hits(120, 14, 50, 1'b0);
        tick();
        drive_hits(140, 16, 51, 1'b0);
        pulse_fe();
        wait_tab("t2", 2);
        pulse_rv();
        wait_done("t2", 2, 1'b0);
        status("t2", 8, 1'b0, 1'b0, 0);

        // 3: 12 stride-kept hits against an 8-point cap, then hits in WAIT
        for (int i = 0; i < 32; i += 4) qb.push_back({11'(200 + i), 10'd52});
        drive_hits(200, 48, 52, 1'b0);
        pulse_fe();
        wait_tab("t3", 2);
        chk("t3_dropped_cap", 32'(dr_b), 4);
        drive_hits(300, 5, 60, 1'b0);
        pulse_rv();
        wait_done("t3", 2, 1'b0);
        status("t3", 8, 1'b0, 1'b0, 9);

        repeat (3) tick();
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
